// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// uart_tx_arbiter: round-robin sharing of one uart_tx serializer between N byte requesters.
// Optional per-message channel locking is enabled by defining ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N-1:0]     req_valid_i,
    input  logic [8*N-1:0]   req_data_i,
    input  logic [N-1:0]     req_last_i,
    output logic [N-1:0]     req_ready_o,
    output logic             tx_e_o,
    output logic [7:0]       tx_d_o,
    input  logic             tx_busy_i,
    output logic [N-1:0]     grant_o,
    output logic             active_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gidx;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   ptr_next;
    logic [IDX_W:0]     sum;
    logic [IDX_W+2:0]   base;
    logic [N-1:0]       eligible;
    logic [N-1:0]       win_oh;
    logic [N-1:0]       ptr_oh;
    logic               found;
    logic               transfer;
    logic               frame_done;

    assign ptr_oh = {{(N-1){1'b0}}, 1'b1} << rr_ptr;

`ifdef ARB_LOCK_EN
    logic lock;
    logic last_q;
    // A locked message owner is the only eligible channel until its last byte.
    assign eligible = lock ? (req_valid_i & ptr_oh) : req_valid_i;
`else
    logic unused_last;
    logic [N-1:0] unused_ptr_oh;
    assign unused_last   = ^req_last_i;
    assign unused_ptr_oh = ptr_oh;
    assign eligible      = req_valid_i;
`endif

    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N))
                sum = sum - (IDX_W+1)'(N);
            if (!found && eligible[sum[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = sum[IDX_W-1:0];
            end
        end
    end

    assign win_oh      = {{(N-1){1'b0}}, 1'b1} << win;
    assign base        = {win, 3'b000};
    assign transfer    = resetn && (state == IDLE) && !tx_busy_i && found;
    assign req_ready_o = transfer ? win_oh : '0;
    assign frame_done  = (state == WAIT_DONE) && !tx_busy_i;
    assign ptr_next    = (gidx == IDX_W'(N-1)) ? '0 : gidx + IDX_W'(1);
    assign active_o    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (transfer) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_ACK;
            WAIT_ACK:  if (tx_busy_i) state_nxt = WAIT_DONE;
            WAIT_DONE: if (!tx_busy_i) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tx_e_o  <= 1'b0;
            tx_d_o  <= 8'h00;
            grant_o <= '0;
            gidx    <= '0;
            rr_ptr  <= '0;
`ifdef ARB_LOCK_EN
            lock    <= 1'b0;
            last_q  <= 1'b0;
`endif
        end else begin
            tx_e_o <= transfer;
            if (transfer) begin
                tx_d_o  <= req_data_i[base +: 8];
                grant_o <= win_oh;
                gidx    <= win;
`ifdef ARB_LOCK_EN
                last_q  <= req_last_i[win];
`endif
            end
            if (frame_done) begin
                grant_o <= '0;
`ifdef ARB_LOCK_EN
                if (!last_q) begin
                    lock   <= 1'b1;
                    rr_ptr <= gidx;
                end else begin
                    lock   <= 1'b0;
                    rr_ptr <= ptr_next;
                end
`else
                rr_ptr <= ptr_next;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// tb_uart_tx_arbiter: directed checks of the round-robin uart_tx arbiter.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        resetn;
    logic [3:0]  req_valid_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_last_i;
    logic [3:0]  req_ready_o;
    logic        tx_e_o;
    logic [7:0]  tx_d_o;
    logic        tx_busy_i;
    logic [3:0]  grant_o;
    logic        active_o;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(.N(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .tx_e_o      (tx_e_o),
        .tx_d_o      (tx_d_o),
        .tx_busy_i   (tx_busy_i),
        .grant_o     (grant_o),
        .active_o    (active_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Acts as the serializer: waits for the enable pulse, then runs a busy frame.
    task automatic serve_one(input string tag, input logic [7:0] exp_d, input logic [3:0] exp_g,
                             input int len, input bit clr);
        bit ok;
        int extra;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx_e_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk({tag, "_pulse"}, {31'd0, ok}, 32'd1);
        chk({tag, "_data"}, {24'd0, tx_d_o}, {24'd0, exp_d});
        chk({tag, "_grant"}, {28'd0, grant_o}, {28'd0, exp_g});
        if (clr) req_valid_i = req_valid_i & ~exp_g;
        tx_busy_i = 1'b1;
        extra = 0;
        repeat (len) begin
            step();
            if (tx_e_o !== 1'b0) extra++;
        end
        chk({tag, "_extra_pulses"}, extra, 0);
        tx_busy_i = 1'b0;
        step();
        chk({tag, "_idle"}, {31'd0, active_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_d [5];
        logic [3:0] exp_g [5];
        int nfr;
        int k0;
        int extra;
        logic [3:0] ready_or;

        resetn      = 1'b0;
        req_valid_i = 4'h0;
        req_data_i  = 32'h0;
        req_last_i  = 4'h0;
        tx_busy_i   = 1'b0;
        repeat (3) step();
        chk("rst_ready", {28'd0, req_ready_o}, 0);
        chk("rst_tx_e", {31'd0, tx_e_o}, 0);
        chk("rst_tx_d", {24'd0, tx_d_o}, 0);
        chk("rst_grant", {28'd0, grant_o}, 0);
        chk("rst_active", {31'd0, active_o}, 0);
        chk("rst_ptr", {30'd0, dut.rr_ptr}, 0);
        resetn = 1'b1;

        // Single request on ch2 with a 40-cycle frame
        req_data_i  = {8'h33, 8'hA5, 8'h22, 8'h11};
        req_valid_i = 4'b0100;
        #1;
        chk("single_ready", {28'd0, req_ready_o}, 32'h4);
        step();
        chk("single_tx_e", {31'd0, tx_e_o}, 1);
        chk("single_tx_d", {24'd0, tx_d_o}, 32'hA5);
        chk("single_grant", {28'd0, grant_o}, 32'h4);
        chk("single_ready_after", {28'd0, req_ready_o}, 0);
        req_valid_i = 4'b0000;
        tx_busy_i   = 1'b1;
        extra = 0;
        repeat (40) begin
            step();
            if (tx_e_o !== 1'b0) extra++;
        end
        chk("single_extra_pulses", extra, 0);
        chk("single_grant_held", {28'd0, grant_o}, 32'h4);
        tx_busy_i = 1'b0;
        step();
        chk("single_idle", {31'd0, active_o}, 0);
        chk("single_grant_clr", {28'd0, grant_o}, 0);
        chk("single_ptr", {30'd0, dut.rr_ptr}, 3);

        // Contention: all channels valid from reset
        resetn      = 1'b0;
        req_valid_i = 4'hF;
        req_data_i  = {8'h13, 8'h12, 8'h11, 8'h10};
        step();
        step();
        chk("cont_rst_ready", {28'd0, req_ready_o}, 0);
        chk("cont_rst_ptr", {30'd0, dut.rr_ptr}, 0);
        resetn = 1'b1;
        #1;
        chk("cont_ready0", {28'd0, req_ready_o}, 32'h1);
        serve_one("cont0", 8'h10, 4'b0001, 12, 1'b0);
        serve_one("cont1", 8'h11, 4'b0010, 12, 1'b0);
        serve_one("cont2", 8'h12, 4'b0100, 12, 1'b0);
        serve_one("cont3", 8'h13, 4'b1000, 12, 1'b0);
        serve_one("cont4", 8'h10, 4'b0001, 12, 1'b0);
        req_valid_i = 4'h0;
        chk("cont_ptr", {30'd0, dut.rr_ptr}, 1);

        // Wrap: move pointer to 3, then ch3 and ch0 compete
        req_data_i  = {8'h00, 8'h42, 8'h00, 8'h00};
        req_valid_i = 4'b0100;
        serve_one("pre_wrap", 8'h42, 4'b0100, 12, 1'b1);
        chk("wrap_ptr_start", {30'd0, dut.rr_ptr}, 3);
        req_data_i  = {8'h83, 8'h00, 8'h00, 8'h80};
        req_valid_i = 4'b1001;
        #1;
        chk("wrap_ready", {28'd0, req_ready_o}, 32'h8);
        serve_one("wrap_ch3", 8'h83, 4'b1000, 12, 1'b1);
        chk("wrap_ptr_0", {30'd0, dut.rr_ptr}, 0);
        serve_one("wrap_ch0", 8'h80, 4'b0001, 12, 1'b1);
        chk("wrap_ptr_1", {30'd0, dut.rr_ptr}, 1);

        // Busy handshake: serializer slow to raise busy
        req_data_i  = {8'h00, 8'h66, 8'h5A, 8'h00};
        req_valid_i = 4'b0010;
        step();
        chk("ack_tx_e", {31'd0, tx_e_o}, 1);
        chk("ack_tx_d", {24'd0, tx_d_o}, 32'h5A);
        req_valid_i = 4'b0110;
        extra    = 0;
        ready_or = 4'h0;
        repeat (5) begin
            step();
            if (tx_e_o !== 1'b0) extra++;
            ready_or = ready_or | req_ready_o;
        end
        chk("ack_no_repulse", extra, 0);
        chk("ack_ready_low", {28'd0, ready_or}, 0);
        chk("ack_state", {30'd0, dut.state}, 2);
        tx_busy_i = 1'b1;
        repeat (8) step();
        tx_busy_i   = 1'b0;
        req_valid_i = 4'h0;
        step();
        chk("ack_idle", {31'd0, active_o}, 0);
        chk("ack_ptr", {30'd0, dut.rr_ptr}, 2);

        // Reset in WAIT_DONE
        req_data_i  = {8'h99, 8'h00, 8'h00, 8'h00};
        req_valid_i = 4'b1000;
        step();
        chk("midrst_tx_e", {31'd0, tx_e_o}, 1);
        req_valid_i = 4'h0;
        tx_busy_i   = 1'b1;
        repeat (3) step();
        chk("midrst_state", {30'd0, dut.state}, 3);
        resetn = 1'b0;
        step();
        chk("midrst_tx_e0", {31'd0, tx_e_o}, 0);
        chk("midrst_tx_d0", {24'd0, tx_d_o}, 0);
        chk("midrst_grant0", {28'd0, grant_o}, 0);
        chk("midrst_active0", {31'd0, active_o}, 0);
        chk("midrst_ptr0", {30'd0, dut.rr_ptr}, 0);
        resetn      = 1'b1;
        tx_busy_i   = 1'b0;
        req_data_i  = {8'h00, 8'h00, 8'h77, 8'h00};
        req_valid_i = 4'b0010;
        serve_one("midrst_ch1", 8'h77, 4'b0010, 12, 1'b1);
        chk("midrst_ptr", {30'd0, dut.rr_ptr}, 2);

        // Multi-byte message on ch0 while ch1 waits
`ifdef ARB_LOCK_EN
        nfr = 4;
        exp_d[0] = 8'hC0; exp_g[0] = 4'b0001;
        exp_d[1] = 8'hC1; exp_g[1] = 4'b0001;
        exp_d[2] = 8'hC2; exp_g[2] = 4'b0001;
        exp_d[3] = 8'hD1; exp_g[3] = 4'b0010;
        exp_d[4] = 8'h00; exp_g[4] = 4'b0000;
`else
        nfr = 5;
        exp_d[0] = 8'hC0; exp_g[0] = 4'b0001;
        exp_d[1] = 8'hD1; exp_g[1] = 4'b0010;
        exp_d[2] = 8'hC1; exp_g[2] = 4'b0001;
        exp_d[3] = 8'hD1; exp_g[3] = 4'b0010;
        exp_d[4] = 8'hC2; exp_g[4] = 4'b0001;
`endif
        k0 = 0;
        req_data_i  = {8'h00, 8'h00, 8'hD1, 8'hC0};
        req_last_i  = 4'b0010;
        req_valid_i = 4'b0011;
        for (int f = 0; f < nfr; f++) begin
            serve_one($sformatf("msg%0d", f), exp_d[f], exp_g[f], 12, 1'b0);
            if (exp_g[f] == 4'b0001) begin
                k0++;
                req_data_i[7:0] = 8'hC0 + 8'(k0);
                req_last_i[0]   = (k0 == 2);
                if (k0 == 3) req_valid_i[0] = 1'b0;
            end
        end
        req_valid_i = 4'h0;
`ifdef ARB_LOCK_EN
        chk("msg_ptr", {30'd0, dut.rr_ptr}, 2);
`else
        chk("msg_ptr", {30'd0, dut.rr_ptr}, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
